// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU ops until both operands are ready,
// snoops the CDB for pending operands and dispatches one ready entry per cycle.
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_op,
  input  logic [31:0]               iss_vj,
  input  logic [31:0]               iss_vk,
  input  logic                      iss_qj_busy,
  input  logic                      iss_qk_busy,
  input  logic [TAG_W-1:0]          iss_qj,
  input  logic [TAG_W-1:0]          iss_qk,
  input  logic [31:0]               iss_addr,
  input  logic [TAG_W-1:0]          iss_dest,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [31:0]               cdb_value,
  output logic                      full,
  output logic [$clog2(ENTRIES):0]  count,
  output logic                      out_valid,
  output logic [4:0]                out_op,
  output logic [31:0]               out_op1,
  output logic [31:0]               out_op2,
  output logic [31:0]               out_addr,
  output logic [TAG_W-1:0]          out_dest
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic [ENTRIES-1:0] r_busy;
  logic [ENTRIES-1:0] r_rj;
  logic [ENTRIES-1:0] r_rk;
  logic [4:0]         r_op   [ENTRIES];
  logic [31:0]        r_vj   [ENTRIES];
  logic [31:0]        r_vk   [ENTRIES];
  logic [31:0]        r_addr [ENTRIES];
  logic [TAG_W-1:0]   r_qj   [ENTRIES];
  logic [TAG_W-1:0]   r_qk   [ENTRIES];
  logic [TAG_W-1:0]   r_dest [ENTRIES];

  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_disp_found;
  logic [IDX_W-1:0]   w_disp_idx;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRIES-1:0] w_wake_j;
  logic [ENTRIES-1:0] w_wake_k;
  logic               w_issue;
  logic               w_byp_j;
  logic               w_byp_k;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_disp_found = 1'b0;
    w_disp_idx   = '0;
    w_count      = '0;
    w_wake_j     = '0;
    w_wake_k     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_busy[i] && r_rj[i] && r_rk[i]) begin
        w_disp_found = 1'b1;
        w_disp_idx   = IDX_W'(i);
      end
      w_count     = w_count + CNT_W'(r_busy[i]);
      w_wake_j[i] = r_busy[i] && !r_rj[i] && cdb_valid && (r_qj[i] == cdb_tag);
      w_wake_k[i] = r_busy[i] && !r_rk[i] && cdb_valid && (r_qk[i] == cdb_tag);
    end
  end

  assign full    = !w_free_found;
  assign count   = w_count;
  assign w_issue = rdy_in && iss_valid && !full && !flush;
  assign w_byp_j = iss_qj_busy && cdb_valid && (iss_qj == cdb_tag);
  assign w_byp_k = iss_qk_busy && cdb_valid && (iss_qk == cdb_tag);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy    <= '0;
      r_rj      <= '0;
      r_rk      <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_addr  <= '0;
      out_dest  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_busy    <= '0;
        r_rj      <= '0;
        r_rk      <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= w_disp_found;
        if (w_disp_found) begin
          out_op             <= r_op[w_disp_idx];
          out_op1            <= r_vj[w_disp_idx];
          out_op2            <= r_vk[w_disp_idx];
          out_addr           <= r_addr[w_disp_idx];
          out_dest           <= r_dest[w_disp_idx];
          r_busy[w_disp_idx] <= 1'b0;
        end
        r_rj <= r_rj | w_wake_j;
        r_rk <= r_rk | w_wake_k;
        // Issue targets a non-busy entry, so it never collides with dispatch or wakeup.
        if (w_issue) begin
          r_busy[w_free_idx] <= 1'b1;
          r_rj[w_free_idx]   <= !iss_qj_busy || w_byp_j;
          r_rk[w_free_idx]   <= !iss_qk_busy || w_byp_k;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_wake_j[i]) r_vj[i] <= cdb_value;
        if (w_wake_k[i]) r_vk[i] <= cdb_value;
      end
      if (w_issue) begin
        r_op[w_free_idx]   <= iss_op;
        r_vj[w_free_idx]   <= w_byp_j ? cdb_value : iss_vj;
        r_vk[w_free_idx]   <= w_byp_k ? cdb_value : iss_vk;
        r_qj[w_free_idx]   <= iss_qj;
        r_qk[w_free_idx]   <= iss_qk;
        r_addr[w_free_idx] <= iss_addr;
        r_dest[w_free_idx] <= iss_dest;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: expected dispatches are queued when issued and
// compared when out_valid is observed.
module tb_alu_rs;
  logic        clk_in, rst_in, rdy_in, flush;
  logic        iss_valid;
  logic [4:0]  iss_op;
  logic [31:0] iss_vj, iss_vk, iss_addr;
  logic        iss_qj_busy, iss_qk_busy;
  logic [3:0]  iss_qj, iss_qk, iss_dest;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        full, out_valid;
  logic [2:0]  count;
  logic [4:0]  out_op;
  logic [31:0] out_op1, out_op2, out_addr;
  logic [3:0]  out_dest;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] addr;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_rs #(.ENTRIES(4), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy),
    .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_addr(iss_addr), .iss_dest(iss_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .full(full), .count(count), .out_valid(out_valid), .out_op(out_op),
    .out_op1(out_op1), .out_op2(out_op2), .out_addr(out_addr), .out_dest(out_dest)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] vj, input logic qjb,
                       input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                       input logic [3:0] qk, input logic [31:0] addr, input logic [3:0] dest);
    iss_valid = 1'b1; iss_op = op; iss_vj = vj; iss_qj_busy = qjb; iss_qj = qj;
    iss_vk = vk; iss_qk_busy = qkb; iss_qk = qk; iss_addr = addr; iss_dest = dest;
  endtask

  task automatic expect_disp(input logic [4:0] op, input logic [31:0] op1,
                             input logic [31:0] op2, input logic [31:0] addr,
                             input logic [3:0] dest);
    exp_t e;
    e.op = op; e.op1 = op1; e.op2 = op2; e.addr = addr; e.dest = dest;
    sb.push_back(e);
  endtask

  task automatic idle();
    iss_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  task automatic step(input logic exp_v);
    exp_t e;
    @(posedge clk_in);
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    if (exp_v && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL scoreboard observed=dispatch expected=empty_queue");
      end else begin
        e = sb.pop_front();
        check("out_op",   {59'd0, out_op},   {59'd0, e.op});
        check("out_op1",  {32'd0, out_op1},  {32'd0, e.op1});
        check("out_op2",  {32'd0, out_op2},  {32'd0, e.op2});
        check("out_addr", {32'd0, out_addr}, {32'd0, e.addr});
        check("out_dest", {60'd0, out_dest}, {60'd0, e.dest});
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    iss_valid = 1'b0; iss_op = '0; iss_vj = '0; iss_vk = '0; iss_addr = '0;
    iss_qj_busy = 1'b0; iss_qk_busy = 1'b0; iss_qj = '0; iss_qk = '0; iss_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_out_op1", {32'd0, out_op1}, 64'd0);
    rst_in = 1'b0;
    step(1'b0);

    // Both operands ready: dispatch one edge after issue.
    issue(5'd0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'h100, 4'd3);
    expect_disp(5'd0, 32'd5, 32'd7, 32'h100, 4'd3);
    step(1'b0);
    check("count_after_issue", {61'd0, count}, 64'd1);
    idle();
    step(1'b1);
    check("count_after_disp", {61'd0, count}, 64'd0);
    step(1'b0);

    // Pending vj woken by CDB two cycles after issue; unrelated tag ignored.
    issue(5'd1, 32'hDEAD, 1'b1, 4'd9, 32'd2, 1'b0, 4'd0, 32'h104, 4'd4);
    expect_disp(5'd1, 32'h1234, 32'd2, 32'h104, 4'd4);
    step(1'b0);
    idle();
    cdb(4'd8, 32'hBAD);
    step(1'b0);
    cdb(4'd9, 32'h1234);
    step(1'b0);
    idle();
    step(1'b1);
    step(1'b0);

    // Same-cycle bypass of vk at issue.
    issue(5'd2, 32'h11, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h108, 4'd5);
    cdb(4'd2, 32'hFF);
    expect_disp(5'd2, 32'h11, 32'hFF, 32'h108, 4'd5);
    step(1'b0);
    idle();
    step(1'b1);

    // Both operands waiting on one tag wake on a single broadcast.
    issue(5'd3, 32'h0, 1'b1, 4'd6, 32'h0, 1'b1, 4'd6, 32'h10C, 4'd6);
    expect_disp(5'd3, 32'h77, 32'h77, 32'h10C, 4'd6);
    step(1'b0);
    idle();
    cdb(4'd6, 32'h77);
    step(1'b0);
    idle();
    step(1'b1);

    // Fill the station, then a fifth issue must be dropped.
    for (int i = 0; i < 4; i++) begin
      issue(5'd4, 32'h0, 1'b1, 4'(10 + i), 32'h20 + i, 1'b0, 4'd0, 32'h200 + 4 * i, 4'(5 + i));
      step(1'b0);
    end
    check("full_at_4", {63'd0, full}, 64'd1);
    check("count_at_4", {61'd0, count}, 64'd4);
    issue(5'd5, 32'h1, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0, 32'h300, 4'd9);
    step(1'b0);
    check("count_fifth_ignored", {61'd0, count}, 64'd4);
    idle();
    cdb(4'd12, 32'hABC);
    expect_disp(5'd4, 32'hABC, 32'h22, 32'h208, 4'd7);
    step(1'b0);
    idle();
    step(1'b1);
    check("full_after_wake", {63'd0, full}, 64'd0);
    check("count_after_wake", {61'd0, count}, 64'd3);

    // Flush discards the remaining entries; later broadcasts wake nothing.
    flush = 1'b1;
    step(1'b0);
    idle();
    check("count_after_flush", {61'd0, count}, 64'd0);
    cdb(4'd10, 32'h1);
    step(1'b0);
    cdb(4'd11, 32'h2);
    step(1'b0);
    cdb(4'd13, 32'h3);
    step(1'b0);
    idle();
    step(1'b0);

    // Stall: nothing moves, flush and CDB ignored, outputs held.
    issue(5'd6, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h400, 4'd1);
    expect_disp(5'd6, 32'h55, 32'h66, 32'h400, 4'd1);
    step(1'b0);
    idle();
    rdy_in = 1'b0;
    flush = 1'b1;
    cdb(4'd1, 32'h999);
    step(1'b0);
    flush = 1'b0;
    step(1'b0);
    step(1'b0);
    check("stall_out_op1_held", {32'd0, out_op1}, {32'd0, 32'hABC});
    check("stall_count_held", {61'd0, count}, 64'd1);
    idle();
    rdy_in = 1'b1;
    step(1'b1);

    // Issue and dispatch in the same edge, then async reset discards a pending entry.
    issue(5'd7, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'h500, 4'd1);
    expect_disp(5'd7, 32'd1, 32'd2, 32'h500, 4'd1);
    step(1'b0);
    issue(5'd8, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'h504, 4'd2);
    expect_disp(5'd8, 32'd3, 32'd4, 32'h504, 4'd2);
    step(1'b1);
    check("count_issue_and_disp", {61'd0, count}, 64'd1);
    issue(5'd9, 32'h0, 1'b1, 4'd3, 32'd5, 1'b0, 4'd0, 32'h508, 4'd10);
    step(1'b1);
    check("count_before_rst", {61'd0, count}, 64'd1);
    idle();
    rst_in = 1'b1;
    #2;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_count", {61'd0, count}, 64'd0);
    check("async_rst_out_dest", {60'd0, out_dest}, 64'd0);
    rst_in = 1'b0;
    cdb(4'd3, 32'h333);
    step(1'b0);
    idle();
    step(1'b0);
    issue(5'd10, 32'hA, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'h600, 4'd11);
    expect_disp(5'd10, 32'hA, 32'hB, 32'h600, 4'd11);
    step(1'b0);
    idle();
    step(1'b1);
    step(1'b0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
